// File: rtl/iterative_shift_unit_if.sv
// rtl/iterative_shift_unit_if.sv - request/result handshake bundle for iterative_shift_unit
//
// Purpose: groups the request side (valid_i/ready_o/data_i/shamt_i/op_i), the result side
//          (valid_o/ready_i/data_o) and the busy_o status flag of the shift unit.
// Modports:
//   master : requester/consumer side (drives request fields and ready_i)
//   slave  : shift unit side (drives ready_o, valid_o, data_o, busy_o)
interface iterative_shift_unit_if #(
    parameter int nb_bits_data  = 32,
    parameter int nb_bits_shamt = 5
);
    logic                     valid_i;
    logic                     ready_o;
    logic [nb_bits_data-1:0]  data_i;
    logic [nb_bits_shamt-1:0] shamt_i;
    logic [1:0]               op_i;
    logic                     valid_o;
    logic                     ready_i;
    logic [nb_bits_data-1:0]  data_o;
    logic                     busy_o;

    modport master (
        output valid_i, data_i, shamt_i, op_i, ready_i,
        input  ready_o, valid_o, data_o, busy_o
    );

    modport slave (
        input  valid_i, data_i, shamt_i, op_i, ready_i,
        output ready_o, valid_o, data_o, busy_o
    );
endinterface

// File: rtl/iterative_shift_unit.sv
// rtl/iterative_shift_unit.sv - multi-cycle SLL/SRL/SRA unit, one log-stage per clock
//
// Purpose: shifts a latched operand by applying fixed stages of 2**k (k = 0..nb_bits_shamt-1),
//          one stage per clock, each only when shamt bit k is set.
// Ports:
//   clk_i    : clock, rising edge
//   rst_n_i  : asynchronous reset, active-low
//   bus      : iterative_shift_unit_if.slave
//              valid_i/ready_o  request handshake (ready_o only in IDLE)
//              data_i/shamt_i/op_i  operand, shift amount, op (00 SLL, 01/10 SRL, 11 SRA)
//              valid_o/ready_i  result handshake (valid_o only in DONE)
//              data_o  result, busy_o  unit not idle
// Configuration:
//   SHIFT_EARLY_EXIT_EN : when defined, stop as soon as no higher shamt bit remains set
//                         (shamt=0 completes at the accept edge). Results are identical.
module iterative_shift_unit #(
    parameter int nb_bits_data  = 32,
    parameter int nb_bits_shamt = 5
) (
    input logic clk_i,
    input logic rst_n_i,
    iterative_shift_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [nb_bits_data-1:0]  work_q;
    logic [nb_bits_data-1:0]  stage_out;
    logic [nb_bits_shamt-1:0] shamt_q;
    logic [nb_bits_shamt-1:0] k_q;
    logic [1:0]               op_q;
    logic                     accept;
    logic                     last_stage;

    assign accept = (state_q == IDLE) && bus.valid_i;

`ifdef SHIFT_EARLY_EXIT_EN
    // Finished once no shamt bit above the stage just applied is set.
    assign last_stage = (((shamt_q >> k_q) >> 1) == '0);
`else
    assign last_stage = (k_q == nb_bits_shamt'(nb_bits_shamt - 1));
`endif

    // One fixed-distance stage, selected by k; the loop unrolls into a small mux of
    // constant shifts rather than a full barrel shifter.
    always_comb begin
        stage_out = work_q;
        for (int i = 0; i < nb_bits_shamt; i++) begin
            if ((int'(k_q) == i) && shamt_q[i]) begin
                case (op_q)
                    2'b00:   stage_out = work_q << (1 << i);
                    2'b11:   stage_out = $unsigned($signed(work_q) >>> (1 << i));
                    default: stage_out = work_q >> (1 << i);
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
`ifdef SHIFT_EARLY_EXIT_EN
                    state_d = (bus.shamt_i == '0) ? DONE : SHIFT;
`else
                    state_d = SHIFT;
`endif
                end
            end
            SHIFT: begin
                if (last_stage) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            work_q  <= '0;
            shamt_q <= '0;
            op_q    <= '0;
            k_q     <= '0;
        end else if (accept) begin
            work_q  <= bus.data_i;
            shamt_q <= bus.shamt_i;
            op_q    <= bus.op_i;
            k_q     <= '0;
        end else if (state_q == SHIFT) begin
            work_q <= stage_out;
            k_q    <= k_q + 1'b1;
        end
    end

    assign bus.ready_o = (state_q == IDLE);
    assign bus.valid_o = (state_q == DONE);
    assign bus.busy_o  = (state_q != IDLE);
    assign bus.data_o  = work_q;
endmodule
